// File: rtl/hack_memory_map_if.sv
// Bus bundle between the Hack CPU / display driver and the data-memory subsystem.
// The slave modport is the memory map; the master modport is the CPU plus display driver.
interface hack_memory_map_if #(
  parameter int FIFO_DEPTH = 8,
  parameter int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
);
  logic [15:0]        addressM;
  logic [15:0]        outM;
  logic               writeM;
  logic [15:0]        inM;
  logic               kbd_valid;
  logic [15:0]        kbd_code;
  logic               scr_valid;
  logic               scr_ready;
  logic [12:0]        scr_addr;
  logic [15:0]        scr_data;
  logic [LEVEL_W-1:0] scr_level;
  logic               scr_overflow;

  modport slave (
    input  addressM, outM, writeM, kbd_valid, kbd_code, scr_ready,
    output inM, scr_valid, scr_addr, scr_data, scr_level, scr_overflow
  );

  modport master (
    output addressM, outM, writeM, kbd_valid, kbd_code, scr_ready,
    input  inM, scr_valid, scr_addr, scr_data, scr_level, scr_overflow
  );
endinterface

// File: rtl/hack_memory_map.sv
// Hack data memory: RAM, screen shadow and keyboard register with a combinational read port,
// plus a screen-write FIFO that feeds the display driver without stalling the CPU.
module hack_memory_map #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  hack_memory_map_if.slave      bus
);
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int LEVEL_W   = $clog2(FIFO_DEPTH + 1);
  localparam int RAM_WORDS = 16384;
  localparam int SCR_WORDS = 8192;

  logic [15:0] ram_q [RAM_WORDS];
  logic [15:0] scr_q [SCR_WORDS];
  logic [28:0] fifo_q [FIFO_DEPTH];

  logic [15:0]        kbd_q, kbd_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               ovf_q, ovf_d;

  logic        is_ram, is_scr, is_kbd;
  logic        push, pop, push_ok, full;
  logic [15:0] rd_data;

  // Decode straight from the top address bits; 0x6001 and above fall through to unmapped.
  assign is_ram = (bus.addressM[15:14] == 2'b00);
  assign is_scr = (bus.addressM[15:13] == 3'b010);
  assign is_kbd = (bus.addressM == 16'h6000);

  assign full    = (level_q == LEVEL_W'(FIFO_DEPTH));
  assign push    = bus.writeM && is_scr;
  assign pop     = (level_q != '0) && bus.scr_ready;
  assign push_ok = push && (!full || pop);

  always_comb begin
    rd_data = 16'h0000;
    if (is_ram) begin
      rd_data = ram_q[bus.addressM[13:0]];
    end else if (is_scr) begin
      rd_data = scr_q[bus.addressM[12:0]];
    end else if (is_kbd) begin
      rd_data = kbd_q;
    end
  end

  assign bus.inM          = rd_data;
  assign bus.scr_valid    = (level_q != '0);
  assign bus.scr_addr     = fifo_q[rd_ptr_q][28:16];
  assign bus.scr_data     = fifo_q[rd_ptr_q][15:0];
  assign bus.scr_level    = level_q;
  assign bus.scr_overflow = ovf_q;

  always_comb begin
    kbd_d    = bus.kbd_valid ? bus.kbd_code : kbd_q;
    wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    ovf_d    = ovf_q || (push && !push_ok);
    level_d  = level_q;
    case ({push_ok, pop})
      2'b10:   level_d = level_q + LEVEL_W'(1);
      2'b01:   level_d = level_q - LEVEL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage arrays are deliberately left out of reset so their contents survive it.
  always_ff @(posedge clk) begin
    if (bus.writeM && is_ram) begin
      ram_q[bus.addressM[13:0]] <= bus.outM;
    end
    if (push) begin
      scr_q[bus.addressM[12:0]] <= bus.outM;
    end
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= {bus.addressM[12:0], bus.outM};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kbd_q    <= 16'h0000;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      kbd_q    <= kbd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end
endmodule

// File: tb/tb_hack_memory_map.sv
// Directed bench for hack_memory_map: scoreboard of expected screen-FIFO entries,
// checked with immediate assertions as the display driver pops them.
module tb_hack_memory_map;
  localparam int DEPTH = 8;

  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic [28:0] sb[$];

  hack_memory_map_if #(.FIFO_DEPTH(DEPTH)) bus ();

  hack_memory_map #(.FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write lands on the following posedge.
  task automatic cpu_write(input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] off;
    bus.addressM = addr;
    bus.outM     = data;
    bus.writeM   = 1'b1;
    if (addr >= 16'h4000 && addr < 16'h6000 && sb.size() < DEPTH) begin
      off = addr - 16'h4000;
      sb.push_back({off[12:0], data});
    end
    @(negedge clk);
    bus.writeM = 1'b0;
  endtask

  task automatic cpu_read(input string tag, input logic [15:0] addr, input logic [15:0] exp);
    bus.addressM = addr;
    #1;
    check(tag, {16'h0, bus.inM}, {16'h0, exp});
  endtask

  task automatic kbd_pulse(input logic [15:0] code);
    bus.kbd_code  = code;
    bus.kbd_valid = 1'b1;
    @(negedge clk);
    bus.kbd_valid = 1'b0;
  endtask

  task automatic pop_check();
    logic [28:0] e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("head_addr", {19'h0, bus.scr_addr}, {19'h0, e[28:16]});
      check("head_data", {16'h0, bus.scr_data}, {16'h0, e[15:0]});
    end
  endtask

  // Head is compared at the negedge before the posedge that pops it.
  task automatic drain(input int exp_n);
    int got = 0;
    bus.scr_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      if (!bus.scr_valid) break;
      pop_check();
      got++;
      @(negedge clk);
    end
    bus.scr_ready = 1'b0;
    check("drain_count", got, exp_n);
    check("drain_sb_empty", sb.size(), 0);
    check("drain_valid_low", {31'h0, bus.scr_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b0;
    bus.addressM  = 16'h0;
    bus.outM      = 16'h0;
    bus.writeM    = 1'b0;
    bus.kbd_valid = 1'b0;
    bus.kbd_code  = 16'h0;
    bus.scr_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    check("rst_valid", {31'h0, bus.scr_valid}, 32'h0);
    check("rst_level", {28'h0, bus.scr_level}, 32'h0);
    check("rst_ovf", {31'h0, bus.scr_overflow}, 32'h0);
    cpu_read("rst_kbd", 16'h6000, 16'h0000);

    cpu_write(16'h0005, 16'h1234);
    cpu_write(16'h3FFF, 16'hBEEF);
    cpu_write(16'h6001, 16'h5555);
    cpu_read("ram5", 16'h0005, 16'h1234);
    cpu_read("ram3fff", 16'h3FFF, 16'hBEEF);
    cpu_read("unmapped_6001", 16'h6001, 16'h0000);
    cpu_read("unmapped_7fff", 16'h7FFF, 16'h0000);
    check("unmapped_no_push", {28'h0, bus.scr_level}, 32'h0);

    cpu_write(16'h4000, 16'hFFFF);
    cpu_write(16'h5FFF, 16'h00F0);
    check("scr_level2", {28'h0, bus.scr_level}, 32'd2);
    drain(2);
    cpu_read("shadow_4000", 16'h4000, 16'hFFFF);
    cpu_read("shadow_5fff", 16'h5FFF, 16'h00F0);

    for (int i = 0; i < 9; i++) cpu_write(16'h4000 + 16'(i), 16'(i + 1));
    check("ovf_level", {28'h0, bus.scr_level}, 32'd8);
    check("ovf_flag", {31'h0, bus.scr_overflow}, 32'h1);
    drain(8);
    cpu_read("ovf_shadow9", 16'h4008, 16'd9);
    check("ovf_sticky", {31'h0, bus.scr_overflow}, 32'h1);

    kbd_pulse(16'd65);
    cpu_read("kbd_65", 16'h6000, 16'd65);
    kbd_pulse(16'd0);
    cpu_read("kbd_0", 16'h6000, 16'd0);
    cpu_write(16'h6000, 16'h1111);
    cpu_read("kbd_cpu_write", 16'h6000, 16'd0);
    check("kbd_write_no_push", {28'h0, bus.scr_level}, 32'h0);

    kbd_pulse(16'h0041);
    for (int i = 0; i < 3; i++) cpu_write(16'h4010 + 16'(i), 16'h0A00 + 16'(i));
    check("pre_rst_level", {28'h0, bus.scr_level}, 32'd3);
    @(posedge clk);
    #2 reset = 1'b0;
    bus.addressM = 16'h6000;
    #1;
    sb.delete();
    check("midrst_valid", {31'h0, bus.scr_valid}, 32'h0);
    check("midrst_level", {28'h0, bus.scr_level}, 32'h0);
    check("midrst_ovf", {31'h0, bus.scr_overflow}, 32'h0);
    check("midrst_kbd", {16'h0, bus.inM}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    cpu_read("ram5_after_rst", 16'h0005, 16'h1234);
    cpu_write(16'h4005, 16'h7777);
    check("post_rst_level", {28'h0, bus.scr_level}, 32'd1);
    drain(1);

    for (int i = 0; i < DEPTH; i++) cpu_write(16'h4100 + 16'(i), 16'h0100 + 16'(i));
    check("full_level", {28'h0, bus.scr_level}, 32'd8);
    bus.scr_ready = 1'b1;
    bus.addressM  = 16'h4200;
    bus.outM      = 16'hAAAA;
    bus.writeM    = 1'b1;
    pop_check();
    sb.push_back({13'h0200, 16'hAAAA});
    @(negedge clk);
    bus.writeM    = 1'b0;
    bus.scr_ready = 1'b0;
    check("pushpop_level", {28'h0, bus.scr_level}, 32'd8);
    check("pushpop_ovf", {31'h0, bus.scr_overflow}, 32'h0);
    drain(8);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hack_memory_map.md
# hack_memory_map

Data-memory subsystem downstream of the Hack CPU: consumes the CPU's `addressM`/`outM`/`writeM` and returns `inM`. Decodes the Hack address map into data RAM, screen memory and keyboard register. Every screen write is also pushed into a small FIFO that feeds the display driver through a valid/ready handshake, so the CPU never stalls on the display.

## Interface
Parameters:
- `FIFO_DEPTH`, 8, screen-write FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addressM`  in  16  CPU data address.
- `outM`  in  16  CPU write data.
- `writeM`  in  1  CPU write strobe.
- `inM`  out  16  read data for `addressM`.
- `kbd_valid`  in  1  one-cycle strobe: new keyboard code available.
- `kbd_code`  in  16  key code; 0 = no key pressed.
- `scr_valid`  out  1  FIFO head entry valid.
- `scr_ready`  in  1  display driver accepts head entry.
- `scr_addr`  out  13  screen word offset of head entry (0..8191).
- `scr_data`  out  16  pixel word of head entry.
- `scr_level`  out  clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- `scr_overflow`  out  1  sticky: a screen write was dropped from FIFO.

## Operation
- Address decode: 0x0000–0x3FFF RAM (16384 words); 0x4000–0x5FFF SCREEN (8192-word shadow RAM); 0x6000 KBD; ≥0x6001 unmapped.
- Read: `inM` is combinational from `addressM`: RAM word, screen shadow word, keyboard register, or 0 for unmapped.
- Write: on rising edge with `writeM`=1, RAM or screen shadow at `addressM` takes `outM`. Writes to KBD and unmapped addresses are ignored (no state change, no FIFO push).
- Screen write additionally pushes {`addressM`-0x4000, `outM`} into the FIFO.
- Keyboard: on rising edge with `kbd_valid`=1, keyboard register loads `kbd_code`; otherwise holds.
- FIFO: `scr_valid`=1 iff occupancy >0; `scr_addr`/`scr_data` show the oldest entry; pop when `scr_valid`&&`scr_ready` at a rising edge. Order is strictly FIFO.
- Push while full and no pop in the same cycle: entry dropped, shadow RAM still updated, `scr_overflow` set and held until reset.
- Push and pop in the same cycle: both occur; occupancy unchanged; legal when full (freed slot taken) and when empty is impossible (no valid head) — push alone applies.
- Read-pointer/write-pointer wrap modulo `FIFO_DEPTH`.

## Timing
- Reset (asynchronous assert, `reset`=0): FIFO empty, `scr_valid`=0, `scr_level`=0, `scr_overflow`=0, keyboard register 0. RAM and screen shadow contents are not cleared. `scr_addr`/`scr_data` are don't-care while `scr_valid`=0.
- Reset mid-operation flushes all queued screen entries; first edge after deassertion behaves as normal operation.
- Read latency 0: `inM` follows `addressM` combinationally; a write at edge N is visible on `inM` after edge N (read-after-write in the same cycle returns old data).
- Screen write at edge N: `scr_valid`=1 after edge N if FIFO was empty; head unchanged otherwise.
- Keyboard strobe at edge N: `inM` at 0x6000 reflects new code after edge N.
- `scr_level` and `scr_overflow` are registered, updated on the same edge as push/pop.

## Test plan
- Reset, then write 0x1234 to RAM[5] and 0xBEEF to RAM[0x3FFF] -> reading 5 gives 0x1234, 0x3FFF gives 0xBEEF; 0x6001 and 0x7FFF read 0; write to 0x6001 changes nothing.
- `scr_ready`=0, write 0xFFFF to 0x4000 then 0x00F0 to 0x5FFF -> `scr_level`=2, head {0, 0xFFFF}; raise `scr_ready` -> next head {8191, 0x00F0}, then `scr_valid`=0; both words read back from shadow.
- `scr_ready`=0, 9 screen writes (data 1..9) with depth 8 -> `scr_level`=8, `scr_overflow`=1, drain yields 1..8 only; reading the 9th address returns 9.
- Full FIFO, simultaneous push (data 0xAAAA) and pop -> `scr_level` stays 8, overflow stays 0, 0xAAAA emerges last.
- `kbd_valid` pulse with code 65 -> 0x6000 reads 65; pulse with 0 -> reads 0; CPU write 0x1111 to 0x6000 -> still 0.
- 3 entries queued, assert `reset` low mid-cycle -> `scr_valid`/`scr_level`/`scr_overflow`/keyboard 0 immediately; RAM[5] still 0x1234 after release.
